// File: rtl/spi_master_ctrl.sv
// SPI initiator: shifts {cmd, cmd_data} out on SS_n/MOSI MSB first, one bit per clk; read-data frames capture 8 MISO bits.
// Latency: SS_n falls the clk after accept (one more with SPI_MASTER_CMD_FIFO_EN); rd_valid pulses in the first gap cycle.
// Backpressure: cmd_ready low for the whole frame and gap; SPI_MASTER_CMD_FIFO_EN adds a 2-deep queue with ready = !full.
module spi_master_ctrl #(
    parameter int RD_LATENCY = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE, LEAD, ROUTE, SHIFT, TAIL, WAIT_RD, CAPTURE, GAP
    } state_t;

    localparam logic [3:0] RD_LAST  = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic [9:0] sreg;
    logic       is_rd;
    logic [6:0] rd_shift;
    logic       ss_n_nxt, mosi_nxt;
    logic       start;
    logic [9:0] start_word;

`ifdef SPI_MASTER_CMD_FIFO_EN
    logic [9:0] fifo_mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] fifo_cnt;
    logic       push;

    assign cmd_ready  = (fifo_cnt != 2'd2) && !rst;
    assign push       = cmd_valid && cmd_ready;
    // Pop straight out of the last gap cycle so queued frames keep the minimum gap.
    assign start      = (fifo_cnt != 2'd0) &&
                        ((state == IDLE) || ((state == GAP) && (cnt == GAP_LAST)));
    assign start_word = fifo_mem[rd_ptr];
    assign busy       = (state != IDLE) || (fifo_cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {cmd, cmd_data};
                wr_ptr           <= ~wr_ptr;
            end
            if (start) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, start};
        end
    end
`else
    assign cmd_ready  = (state == IDLE) && !rst;
    assign start      = cmd_valid && cmd_ready;
    assign start_word = {cmd, cmd_data};
    assign busy       = (state != IDLE);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LEAD;
            LEAD:    state_nxt = ROUTE;
            ROUTE:   state_nxt = SHIFT;
            SHIFT:   if (cnt == 4'd9) state_nxt = is_rd ? WAIT_RD : TAIL;
            TAIL:    state_nxt = GAP;
            WAIT_RD: if (cnt == RD_LAST) state_nxt = CAPTURE;
            CAPTURE: if (cnt == 4'd7) state_nxt = GAP;
            GAP:     if (cnt == GAP_LAST) state_nxt = start ? LEAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pins are registered from the next state so they only move on rising edges.
    always_comb begin
        ss_n_nxt = (state_nxt == IDLE) || (state_nxt == GAP);
        mosi_nxt = 1'b0;
        case (state_nxt)
            ROUTE:   mosi_nxt = sreg[9];
            SHIFT:   mosi_nxt = (state == SHIFT) ? sreg[8] : sreg[9];
            default: mosi_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            sreg     <= 10'd0;
            is_rd    <= 1'b0;
            rd_shift <= 7'd0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            state    <= state_nxt;
            SS_n     <= ss_n_nxt;
            MOSI     <= mosi_nxt;
            rd_valid <= 1'b0;
            if ((state_nxt != state) || (state == IDLE)) begin
                cnt <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
            if (start) begin
                sreg  <= start_word;
                is_rd <= (start_word[9:8] == 2'b11);
            end else if (state == SHIFT) begin
                sreg <= {sreg[8:0], 1'b0};
            end
            if (state == CAPTURE) begin
                rd_shift <= {rd_shift[5:0], MISO};
                if (cnt == 4'd7) begin
                    rd_data  <= {rd_shift, MISO};
                    rd_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a per-cycle timeline model of the pins plus directed frames and literal expectations.
module tb_spi_master_ctrl;
    localparam int RL  = 2;
    localparam int GAP = 1;
`ifdef SPI_MASTER_CMD_FIFO_EN
    localparam bit FIFO    = 1'b1;
    localparam int ACC_LAT = 1;
`else
    localparam bit FIFO    = 1'b0;
    localparam int ACC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_valid4 = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, rd_valid, busy, ss_n, mosi;
    logic       cmd_ready4, rd_valid4, busy4, ss_n4, mosi4;
    logic [7:0] rd_data, rd_data4;
    logic       miso = 1'b0, miso4 = 1'b0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.RD_LATENCY(RL), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_data(cmd_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .SS_n(ss_n), .MOSI(mosi), .MISO(miso));

    spi_master_ctrl #(.RD_LATENCY(4), .GAP_CYCLES(GAP)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd(cmd), .cmd_data(cmd_data), .rd_data(rd_data4), .rd_valid(rd_valid4),
        .busy(busy4), .SS_n(ss_n4), .MOSI(mosi4), .MISO(miso4));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- model: one entry per expected clk cycle ----------------
    typedef struct packed {
        logic       ss_n;
        logic       mosi;
        logic       busy;
        logic       rdv;
        logic       miso;
        logic       ready;
        logic [7:0] rdd;
    } ent_t;

    localparam ent_t IDLE_E = '{ss_n: 1'b1, mosi: 1'b0, busy: 1'b0, rdv: 1'b0,
                                miso: 1'b0, ready: 1'b1, rdd: 8'h00};

    ent_t       q[$];
    logic [9:0] pend[$];
    ent_t       cur = IDLE_E;
    logic       cur_rdy = 1'b0;
    logic       chk_en = 1'b0;
    logic [7:0] exp_rd = 8'h00;
    logic [7:0] miso_byte = 8'h00;
    logic       e_rdy, e_busy;

    function automatic ent_t fe(input logic s, input logic m, input logic v,
                                input logic mi, input logic [7:0] dd);
        ent_t e;
        e.ss_n = s; e.mosi = m; e.busy = 1'b1; e.rdv = v;
        e.miso = mi; e.ready = 1'b0; e.rdd = dd;
        return e;
    endfunction

    task automatic add_frame(input logic [9:0] w);
        logic [7:0] rep;
        rep = (w[9:8] == 2'b11) ? miso_byte : 8'h00;
        q.push_back(fe(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        q.push_back(fe(1'b0, w[9], 1'b0, 1'b0, 8'h00));
        for (int i = 9; i >= 0; i--) q.push_back(fe(1'b0, w[i], 1'b0, 1'b0, 8'h00));
        if (w[9:8] != 2'b11) begin
            q.push_back(fe(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        end else begin
            for (int i = 0; i < RL; i++) q.push_back(fe(1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
            for (int k = 7; k >= 0; k--) q.push_back(fe(1'b0, 1'b0, 1'b0, rep[k], 8'h00));
        end
        for (int g = 0; g < GAP; g++)
            q.push_back(fe(1'b1, 1'b0, (w[9:8] == 2'b11) && (g == 0), 1'b0, rep));
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            pend.delete();
            exp_rd = 8'h00;
            chk_en = 1'b1;
        end else if (FIFO) begin
            if (q.size() == 0 && pend.size() > 0) add_frame(pend.pop_front());
            if (cmd_valid && cur_rdy) pend.push_back({cmd, cmd_data});
        end else begin
            if (q.size() == 0 && cmd_valid && cur_rdy) add_frame({cmd, cmd_data});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
            if (cur.rdv) exp_rd = cur.rdd;
            miso   = cur.miso;
            e_rdy  = FIFO ? (pend.size() < 2) : cur.ready;
            e_busy = cur.busy || (pend.size() > 0);
            chk("SS_n",      32'(ss_n),      32'(cur.ss_n));
            chk("MOSI",      32'(mosi),      32'(cur.mosi));
            chk("busy",      32'(busy),      32'(e_busy));
            chk("rd_valid",  32'(rd_valid),  32'(cur.rdv));
            chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy && !rst));
            chk("rd_data",   32'(rd_data),   32'(exp_rd));
            cur_rdy = e_rdy;
        end
    end

    // ---------------- frame recorders ----------------
    logic [31:0] frm_bits = 0, last_bits = 0;
    int frm_len = 0, last_len = 0, hi_run = 0, last_hi = 0, rdv_cnt = 0;
    int len4 = 0, last_len4 = 0, rdv4_cnt = 0;
    logic [7:0] pat4 = 8'h5A;

    always @(negedge clk) begin
        if (ss_n === 1'b0) begin
            if (frm_len == 0) last_hi = hi_run;
            hi_run   = 0;
            frm_bits = {frm_bits[30:0], mosi};
            frm_len++;
        end else begin
            hi_run++;
            if (frm_len != 0) begin
                last_bits = frm_bits;
                last_len  = frm_len;
                frm_bits  = 0;
                frm_len   = 0;
            end
        end
        if (rd_valid === 1'b1) rdv_cnt++;
    end

    // Slave stand-in for the RD_LATENCY=4 instance: drives 0x5A MSB first in low cycles 16..23.
    always @(negedge clk) begin
        if (ss_n4 === 1'b0) begin
            miso4 = (len4 >= 16 && len4 <= 23) ? pat4[23 - len4] : 1'b0;
            len4++;
        end else begin
            if (len4 != 0) last_len4 = len4;
            len4  = 0;
            miso4 = 1'b0;
        end
        if (rd_valid4 === 1'b1) rdv4_cnt++;
    end

    // ---------------- host driver (called just after a rising edge) ----------------
    task automatic send(input logic [1:0] c, input logic [7:0] d);
        int n = 0;
        cmd = c; cmd_data = d; cmd_valid = 1'b1;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("send_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || q.size() != 0 || pend.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("idle_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_SS_n",      32'(ss_n),      32'(1));
        chk("rst_MOSI",      32'(mosi),      32'(0));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        chk("rst_rd_data",   32'(rd_data),   32'(8'h00));
        chk("rst_busy",      32'(busy),      32'(0));
        chk("rst_rd_data4",  32'(rd_data4),  32'(8'h00));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 32'(1));
        @(posedge clk);
        #1;

        // Write address 0x33
        send(2'b00, 8'h33);
        wait_idle();
        chk("wa_len",  32'(last_len), 32'(13));
        chk("wa_mosi", 32'(last_bits[12:0]), 32'(13'b0000001100110));
        chk("wa_rdv",  32'(rdv_cnt), 32'(0));

        // Write data, read address, read data back-to-back with valid held
        send(2'b01, 8'hFF);
        send(2'b10, 8'h33);
        miso_byte = 8'hA5;
        send(2'b11, 8'h00);
        wait_idle();
        chk("rd_len",  32'(last_len), 32'(22));
        chk("rd_data", 32'(rd_data), 32'(8'hA5));
        chk("rd_rdv",  32'(rdv_cnt), 32'(1));
        chk("rd_gap",  32'(last_hi), 32'(FIFO ? 1 : 2));

        // Reset during SHIFT bit 5 of a write frame
        send(2'b00, 8'hC3);
        repeat (7 + ACC_LAT) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_SS_n",    32'(ss_n), 32'(1));
        chk("abort_rd_data", 32'(rd_data), 32'(8'h00));
        @(negedge clk);
        chk("abort_len", 32'(last_len), 32'(8));
        @(posedge clk);
        #1;
        send(2'b01, 8'h5C);
        wait_idle();
        chk("post_len",  32'(last_len), 32'(13));
        chk("post_mosi", 32'(last_bits[12:0]), 32'(13'b0001010111000));
        chk("post_rdv",  32'(rdv_cnt), 32'(1));

        // Loopback byte 0x5A, then rd_data must hold across a write frame
        send(2'b00, 8'h40);
        send(2'b01, 8'h5A);
        send(2'b10, 8'h40);
        miso_byte = 8'h5A;
        send(2'b11, 8'h00);
        wait_idle();
        chk("lb_data", 32'(rd_data), 32'(8'h5A));
        chk("lb_len",  32'(last_len), 32'(22));
        send(2'b00, 8'h11);
        wait_idle();
        chk("hold_data", 32'(rd_data), 32'(8'h5A));
        chk("hold_rdv",  32'(rdv_cnt), 32'(2));

`ifdef SPI_MASTER_CMD_FIFO_EN
        send(2'b00, 8'h21);
        send(2'b01, 8'h22);
        send(2'b10, 8'h23);
        @(negedge clk);
        chk("fifo_full_ready", 32'(cmd_ready), 32'(0));
        @(posedge clk);
        #1;
        wait_idle();
        chk("fifo_gap", 32'(last_hi), 32'(GAP));
`endif

        // RD_LATENCY=4 instance: read-data frame with capture 2 cycles later
        begin
            int n = 0;
            cmd = 2'b11; cmd_data = 8'h00; cmd_valid4 = 1'b1;
            @(negedge clk);
            while (cmd_ready4 !== 1'b1 && n < 400) begin @(negedge clk); n++; end
            if (n >= 400) chk("send4_timeout", 32'(n), 32'(0));
            @(posedge clk);
            #1 cmd_valid4 = 1'b0;
            n = 0;
            @(negedge clk);
            while (busy4 !== 1'b0 && n < 400) begin @(negedge clk); n++; end
            if (n >= 400) chk("idle4_timeout", 32'(n), 32'(0));
        end
        chk("rl4_data", 32'(rd_data4), 32'(8'h5A));
        chk("rl4_len",  32'(last_len4), 32'(24));
        chk("rl4_rdv",  32'(rdv4_cnt), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
